// File: rtl/adder16_arbiter_if.sv
// adder16_arbiter_if: request/response bundle between the clients and the shared adder arbiter.
//   req_valid/req_ready  per-requester handshake (NREQ bits)
//   req_a/req_b          packed 16-bit operands, requester i at [16*i+15:16*i]
//   rsp_valid/rsp_ready  single response channel handshake
//   rsp_sum/rsp_ovfl     registered sum and carry out of bit 15
//   rsp_id               requester index that produced the response
//   op_count             completed request-side transfers, wraps at 16 bits
interface adder16_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*16-1:0] req_a;
    logic [NREQ*16-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [15:0]        rsp_sum;
    logic               rsp_ovfl;
    logic [IDW-1:0]     rsp_id;
    logic [15:0]        op_count;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_ovfl, rsp_id, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_ovfl, rsp_id, op_count
    );
endinterface

// File: rtl/adder16_arbiter.sv
// adder16_arbiter: round-robin sharing of one 16-bit adder among NREQ requesters with a registered response.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    adder16_arbiter_if.slave: request handshake/operands in, tagged response and op_count out
module adder16_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input logic              clk,
    input logic              rst_n,
    adder16_arbiter_if.slave bus
);
    typedef enum logic {IDLE, FULL} state_t;

    state_t             state, state_nx;
    logic [IDW-1:0]     rr_ptr, off, win, ptr_nx, id_q;
    logic [IDW:0]       win_sum;
    logic [2*NREQ-1:0]  dbl;
    logic [NREQ-1:0]    rot;
    logic               can_accept, grant, ovfl_q;
    logic [15:0]        op_a, op_b, sum_q, cnt_q;
    logic [16:0]        add;

    // Rotating the doubled request vector by rr_ptr puts the search start at bit 0,
    // so the lowest set bit of rot is the round-robin winner's offset from rr_ptr.
    always_comb begin
        dbl = {bus.req_valid, bus.req_valid} >> rr_ptr;
        rot = dbl[NREQ-1:0];
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rot[k]) off = IDW'(k);
        win_sum = {1'b0, rr_ptr} + {1'b0, off};
        win = (win_sum >= (IDW+1)'(NREQ)) ? IDW'(win_sum - (IDW+1)'(NREQ)) : win_sum[IDW-1:0];
        ptr_nx = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
        op_a = '0;
        op_b = '0;
        for (int k = 0; k < NREQ; k++)
            if (win == IDW'(k)) begin
                op_a = bus.req_a[16*k +: 16];
                op_b = bus.req_b[16*k +: 16];
            end
        add = {1'b0, op_a} + {1'b0, op_b};
        can_accept = (state == IDLE) | bus.rsp_ready;
        grant = can_accept & (|bus.req_valid);
        bus.req_ready = grant ? (NREQ'(1) << win) : '0;
        state_nx = grant ? FULL : ((state == FULL) && bus.rsp_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Result fields only change on a transfer, so a plain drain leaves them holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            ovfl_q <= 1'b0;
            id_q   <= '0;
            rr_ptr <= '0;
            cnt_q  <= '0;
        end else if (grant) begin
            sum_q  <= add[15:0];
            ovfl_q <= add[16];
            id_q   <= win;
            rr_ptr <= ptr_nx;
            cnt_q  <= cnt_q + 16'd1;
        end
    end

    assign bus.rsp_valid = (state == FULL);
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_ovfl  = ovfl_q;
    assign bus.rsp_id    = id_q;
    assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_adder16_arbiter.sv
// tb_adder16_arbiter: directed stimulus checked every cycle against a behavioural round-robin adder model.
module tb_adder16_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NREQ-1:0] valid;
    logic            rdy;
    logic [15:0]     a [NREQ];
    logic [15:0]     b [NREQ];
    int              vectors = 0;
    int              miscompares = 0;

    logic            m_full;
    logic [15:0]     m_sum, m_cnt;
    logic            m_ovfl;
    int              m_id, m_ptr;

    always #5 clk = ~clk;

    adder16_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
    adder16_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    assign bus.req_valid = valid;
    assign bus.rsp_ready = rdy;
    assign bus.req_a     = {a[3], a[2], a[1], a[0]};
    assign bus.req_b     = {b[3], b[2], b[1], b[0]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_winner();
        if (m_full && !rdy) return -1;
        for (int k = 0; k < NREQ; k++)
            if (valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int w = exp_winner();
        return (w < 0) ? 4'b0000 : 4'(1 << w);
    endfunction

    function automatic int sum_of(int w);
        return int'(a[w]) + int'(b[w]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full <= 1'b0;
            m_sum  <= '0;
            m_ovfl <= 1'b0;
            m_id   <= 0;
            m_ptr  <= 0;
            m_cnt  <= '0;
        end else if (exp_winner() >= 0) begin
            m_full <= 1'b1;
            m_sum  <= 16'(sum_of(exp_winner()));
            m_ovfl <= sum_of(exp_winner()) > 65535;
            m_id   <= exp_winner();
            m_ptr  <= (exp_winner() + 1) % NREQ;
            m_cnt  <= m_cnt + 16'd1;
        end else if (m_full && rdy) begin
            m_full <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready()));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(m_full));
        check("rsp_sum",   32'(bus.rsp_sum),   32'(m_sum));
        check("rsp_ovfl",  32'(bus.rsp_ovfl),  32'(m_ovfl));
        check("rsp_id",    32'(bus.rsp_id),    32'(m_id));
        check("op_count",  32'(bus.op_count),  32'(m_cnt));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        valid = '0;
        rdy   = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        #1;
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_count", 32'(bus.op_count), 32'd0);
        tick();
        rst_n = 1'b1;
        // single requester, plain add
        a[0] = 16'h1234;
        b[0] = 16'h0001;
        valid = 4'b0001;
        #1 check("t1_grant", 32'(bus.req_ready), 32'h1);
        tick();
        check("t1_valid", 32'(bus.rsp_valid), 32'd1);
        check("t1_sum",   32'(bus.rsp_sum),   32'h1235);
        check("t1_ovfl",  32'(bus.rsp_ovfl),  32'd0);
        check("t1_id",    32'(bus.rsp_id),    32'd0);
        check("t1_count", 32'(bus.op_count),  32'd1);
        valid = '0;
        // carry out of bit 15
        a[3] = 16'hFFFF;
        b[3] = 16'h0001;
        valid = 4'b1000;
        #1 check("t2_grant", 32'(bus.req_ready), 32'h8);
        tick();
        check("t2_sum",  32'(bus.rsp_sum),  32'h0000);
        check("t2_ovfl", 32'(bus.rsp_ovfl), 32'd1);
        check("t2_id",   32'(bus.rsp_id),   32'd3);
        a[3] = 16'h8000;
        b[3] = 16'h8000;
        #1 check("t2b_grant", 32'(bus.req_ready), 32'h8);
        tick();
        check("t2b_sum",   32'(bus.rsp_sum),  32'h0000);
        check("t2b_ovfl",  32'(bus.rsp_ovfl), 32'd1);
        check("t2b_count", 32'(bus.op_count), 32'd3);
        valid = '0;
        tick();
        check("t2_drain", 32'(bus.rsp_valid), 32'd0);
        // all requesters busy: strict rotation at full throughput
        for (int i = 0; i < NREQ; i++) begin
            a[i] = 16'(i * 16'h1111);
            b[i] = 16'(16'h0100 + i);
        end
        valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 check("t3_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
            tick();
            check("t3_id",    32'(bus.rsp_id),    32'(k % 4));
            check("t3_valid", 32'(bus.rsp_valid), 32'd1);
        end
        valid = '0;
        tick();
        check("t3_count", 32'(bus.op_count),  32'd11);
        check("t3_drain", 32'(bus.rsp_valid), 32'd0);
        // backpressure then drain-and-grant in one cycle
        rdy = 1'b0;
        valid = 4'b0110;
        #1 check("t4_grant", 32'(bus.req_ready), 32'h2);
        tick();
        check("t4_id",  32'(bus.rsp_id),  32'd1);
        check("t4_sum", 32'(bus.rsp_sum), 32'h1212);
        valid = 4'b0100;
        repeat (3) begin
            #1 check("t4_stall", 32'(bus.req_ready), 32'h0);
            tick();
            check("t4_hold_v",   32'(bus.rsp_valid), 32'd1);
            check("t4_hold_id",  32'(bus.rsp_id),    32'd1);
            check("t4_hold_sum", 32'(bus.rsp_sum),   32'h1212);
        end
        rdy = 1'b1;
        #1 check("t4_grant2", 32'(bus.req_ready), 32'h4);
        tick();
        check("t4_valid", 32'(bus.rsp_valid), 32'd1);
        check("t4_id2",   32'(bus.rsp_id),    32'd2);
        check("t4_sum2",  32'(bus.rsp_sum),   32'h2324);
        check("t4_count", 32'(bus.op_count),  32'd13);
        valid = '0;
        tick();
        check("t4_drain", 32'(bus.rsp_valid), 32'd0);
        // pointer skip: bring rr_ptr to 1, then only 0 and 2 request
        valid = 4'b0001;
        tick();
        valid = 4'b0101;
        #1 check("t5_grant", 32'(bus.req_ready), 32'h4);
        tick();
        check("t5_id", 32'(bus.rsp_id), 32'd2);
        valid = 4'b0001;
        #1 check("t5_grant2", 32'(bus.req_ready), 32'h1);
        tick();
        check("t5_id2",   32'(bus.rsp_id),   32'd0);
        check("t5_count", 32'(bus.op_count), 32'd16);
        // asynchronous reset mid-stream
        valid = 4'b1111;
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(bus.rsp_valid), 32'd0);
        check("t6_count", 32'(bus.op_count),  32'd0);
        check("t6_sum",   32'(bus.rsp_sum),   32'd0);
        check("t6_id",    32'(bus.rsp_id),    32'd0);
        valid = 4'b1010;
        tick();
        rst_n = 1'b1;
        #1 check("t6_grant", 32'(bus.req_ready), 32'h2);
        tick();
        check("t6_id2",   32'(bus.rsp_id),   32'd1);
        check("t6_count2", 32'(bus.op_count), 32'd1);
        valid = '0;
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
